div32: RTL

//  Multi-cycle 32-bit integer divider for the MIPS datapath (DIV/DIVU).

---
 rtl/div32.sv | 130 +++++++++++++
 1 files changed

// File: rtl/div32.sv
// Multi-cycle restoring divider (DIV/DIVU), one quotient bit per clock; 34 edges start-to-done
// (1 edge when b==0). No backpressure: start is taken only in IDLE/DONE and ignored while busy.
module div32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] prem;
    logic [WIDTH-1:0] qsr;
    logic [WIDTH-1:0] dmag;
    logic             q_neg;
    logic             r_neg;

    logic             accept;
    logic             last_iter;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   prem_sh;
    logic [WIDTH:0]   diff;

    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last_iter = (cnt == CW'(WIDTH - 1));

    assign a_mag = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign b_mag = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

    // The stored partial remainder is always below the divisor, so it fits in
    // WIDTH bits; the extra top bit only exists in the trial subtraction as borrow.
    assign prem_sh = {prem, qsr[WIDTH-1]};
    assign diff    = prem_sh - {1'b0, dmag};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
                    state_nxt = (b == '0) ? DONE : CALC;
                end else if (state == DONE) begin
                    state_nxt = IDLE;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            prem      <= '0;
            qsr       <= '0;
            dmag      <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            prem  <= '0;
            qsr   <= a_mag;
            dmag  <= b_mag;
            q_neg <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg <= is_signed && a[WIDTH-1];
            if (b == '0) begin
                quotient  <= '1;
                remainder <= a;
                div_zero  <= 1'b1;
            end
        end else if (state == CALC) begin
            cnt <= last_iter ? '0 : cnt + CW'(1);
            // Dividend bits shift out of qsr's top while quotient bits shift in below.
            if (!diff[WIDTH]) begin
                prem <= diff[WIDTH-1:0];
                qsr  <= {qsr[WIDTH-2:0], 1'b1};
            end else begin
                prem <= prem_sh[WIDTH-1:0];
                qsr  <= {qsr[WIDTH-2:0], 1'b0};
            end
        end else if (state == FIX) begin
            quotient  <= q_neg ? (~qsr + WIDTH'(1)) : qsr;
            remainder <= r_neg ? (~prem + WIDTH'(1)) : prem;
            div_zero  <= 1'b0;
        end
    end

endmodule
